// File: rtl/lsu_bus.sv
// lsu_bus: turns one RV32I core load/store into a single valid/ready bus
// transaction with byte enables, lane-replicated store data and load
// extension; reports misaligned, illegal-width and timed-out accesses.
// Ports: clk, reset (async, active-high); core side req/we/funct3/addr/wdata
// in, stall/done/rdata/fault/fault_cause out; bus side bus_valid/bus_we/
// bus_addr/bus_be/bus_wdata out, bus_ready/bus_rdata in.
module lsu_bus #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] rdata_q, rdata_d;

    logic        illegal;
    logic        misalign;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] ext;

    // Request decode: illegal is checked before misalignment.
    always_comb begin
        illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                   (funct3 == 3'b111) || (we && funct3[2]);
        misalign = (funct3[1:0] == 2'b01 && addr[0]) ||
                   (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        be_n = 4'b1111;
        wd_n = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                be_n = 4'b0001 << addr[1:0];
                wd_n = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_n = 4'b0011 << addr[1:0];
                wd_n = {2{wdata[15:0]}};
            end
            default: begin
                be_n = 4'b1111;
                wd_n = wdata;
            end
        endcase
    end

    // Load extension from the saved lane offset.
    always_comb begin
        shifted = bus_rdata >> {off_q, 3'b000};
        half    = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ext     = bus_rdata;
        unique case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b001:  ext = {{16{half[15]}}, half};
            3'b101:  ext = {16'h0, half};
            default: ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        fault_d   = fault_q;
        cause_d   = cause_q;
        rdata_d   = rdata_q;
        stall     = 1'b0;
        done      = 1'b0;
        bus_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall   = req;
                fault_d = 1'b0;
                cause_d = 2'b00;
                rdata_d = 32'h0;
                if (req) begin
                    if (illegal) begin
                        fault_d = 1'b1;
                        cause_d = 2'b11;
                        state_d = RESP;
                    end else if (misalign) begin
                        fault_d = 1'b1;
                        cause_d = 2'b01;
                        state_d = RESP;
                    end else begin
                        we_d    = we;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = be_n;
                        wdata_d = wd_n;
                        f3_d    = funct3;
                        off_d   = addr[1:0];
                        cnt_d   = 8'd0;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                stall     = 1'b1;
                bus_valid = 1'b1;
                if (bus_ready) begin
                    rdata_d = we_q ? 32'h0 : ext;
                    state_d = RESP;
                end else begin
                    // Exits on reaching TIMEOUT, so the counter never wraps.
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == TIMEOUT_W) begin
                        fault_d = 1'b1;
                        cause_d = 2'b10;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_be      = be_q;
    assign bus_wdata   = wdata_q;
    assign rdata       = rdata_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_lsu_bus.sv
// tb_lsu_bus: randomized and directed scoreboard bench for lsu_bus.
// Expected responses are queued at issue and checked by a negedge monitor.
module tb_lsu_bus;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    lsu_bus #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done),
        .rdata(rdata), .fault(fault), .fault_cause(fault_cause),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic        flt;
        logic [1:0]  cause;
        logic [31:0] rd;
        int          nv;
        int          start;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    rsp_t rq[$];
    bus_t bq[$];
    rsp_t r_m;
    bus_t b_m;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   vcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk) begin
        if (reset) begin
            vcnt = 0;
        end else begin
            if (bus_valid) vcnt++;
            if (bus_valid && bus_ready) begin
                if (bq.size() == 0) begin
                    chk("bus_unexpected", 1, 0);
                end else begin
                    b_m = bq.pop_front();
                    chk("bus_we", 32'(bus_we), 32'(b_m.we));
                    chk("bus_addr", bus_addr, b_m.a);
                    chk("bus_be", 32'(bus_be), 32'(b_m.be));
                    chk("bus_wdata", bus_wdata, b_m.wd);
                end
            end
            if (req) chk("stall", 32'(stall), 32'(!done));
            if (done) begin
                if (rq.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    r_m = rq.pop_front();
                    chk("fault", 32'(fault), 32'(r_m.flt));
                    chk("cause", 32'(fault_cause), 32'(r_m.cause));
                    chk("rdata", rdata, r_m.rd);
                    chk("latency", cyc - r_m.start, r_m.lat);
                    chk("valid_cycles", vcnt, r_m.nv);
                end
                vcnt = 0;
            end
        end
    end

    // Starts in an IDLE cycle at posedge+1 and returns in the next one.
    task automatic do_op(input logic w_e, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] word, input int w,
                         input bit to, input int gap);
        rsp_t        r;
        bus_t        b;
        bit          ill, mis, nobus, got;
        int          sz, off, k;
        logic [31:0] v;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        sz  = int'(f3) % 4;
        off = int'(a % 4);
        ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (w_e && f3[2]);
        mis = (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
        nobus = ill || mis;
        r.start = cyc;
        r.rd = 32'h0;
        if (ill) begin
            r.flt = 1; r.cause = 2'b11; r.lat = 1; r.nv = 0;
        end else if (mis) begin
            r.flt = 1; r.cause = 2'b01; r.lat = 1; r.nv = 0;
        end else if (to) begin
            r.flt = 1; r.cause = 2'b10; r.lat = TO + 1; r.nv = TO;
        end else begin
            r.flt = 0; r.cause = 2'b00; r.lat = w + 2; r.nv = w + 1;
            b.we = w_e;
            b.a  = a & ~32'd3;
            if (sz == 0) begin
                b.be = 4'(1 << off);
                b.wd = (wd & 32'hFF) * 32'h01010101;
            end else if (sz == 1) begin
                b.be = 4'(3 << off);
                b.wd = (wd & 32'hFFFF) * 32'h00010001;
            end else begin
                b.be = 4'hF;
                b.wd = wd;
            end
            bq.push_back(b);
            if (!w_e) begin
                if (sz == 0) begin
                    v = (word >> (8 * off)) & 32'hFF;
                    if (!f3[2] && v >= 128) v = v | 32'hFFFFFF00;
                end else if (sz == 1) begin
                    v = (word >> (8 * off)) & 32'hFFFF;
                    if (!f3[2] && v >= 32768) v = v | 32'hFFFF0000;
                end else begin
                    v = word;
                end
                r.rd = v;
            end
        end
        rq.push_back(r);
        req = 1; we = w_e; funct3 = f3; addr = a; wdata = wd;
        bus_ready = 0; bus_rdata = word;
        k = 0;
        got = 0;
        while (!got && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            bus_ready = !nobus && !to && (k == w + 1);
            if (done) got = 1;
        end
        if (!got) chk("done_timeout", 0, 1);
        @(posedge clk);
        #1;
        req = 0;
        bus_ready = 0;
    endtask

    initial begin
        reset = 1; req = 0; we = 0; funct3 = 0; addr = 0; wdata = 0;
        bus_ready = 0; bus_rdata = 0;
        #12;
        chk("rst_done", 32'(done), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_cause", 32'(fault_cause), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bus_valid", 32'(bus_valid), 0);
        chk("rst_bus_we", 32'(bus_we), 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_be", 32'(bus_be), 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_stall_lo", 32'(stall), 0);
        req = 1;
        #1;
        chk("rst_stall_hi", 32'(stall), 1);
        req = 0;
        @(posedge clk);
        #1;
        reset = 0;

        do_op(1, 3'b010, 32'h64, 32'h19, 32'h0, 0, 0, 0);
        do_op(1, 3'b000, 32'h103, 32'hAB, 32'h0, 1, 0, 0);
        do_op(0, 3'b001, 32'h22, 32'h0, 32'h80017FFF, 2, 0, 1);
        do_op(0, 3'b101, 32'h22, 32'h0, 32'h80017FFF, 0, 0, 0);
        do_op(0, 3'b000, 32'h21, 32'h0, 32'h80017FFF, 3, 0, 0);
        do_op(0, 3'b010, 32'h66, 32'h0, 32'h0, 0, 0, 0);
        do_op(1, 3'b100, 32'h40, 32'h5, 32'h0, 0, 0, 0);
        do_op(0, 3'b010, 32'h40, 32'h0, 32'h12345678, 0, 1, 0);
        do_op(1, 3'b001, 32'h42, 32'hBEEF, 32'h0, 0, 0, 2);

        req = 1; we = 0; funct3 = 3'b010; addr = 32'h200; bus_ready = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_valid", 32'(bus_valid), 1);
        #2;
        reset = 1;
        #1;
        chk("mid_rst_valid", 32'(bus_valid), 0);
        chk("mid_rst_done", 32'(done), 0);
        req = 0;
        @(posedge clk);
        #1;
        reset = 0;
        do_op(0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 1, 0, 0);

        for (int i = 0; i < 150; i++) begin
            do_op(1'($urandom), 3'($urandom),
                  ($urandom & 32'hFFFFFFF0) | 32'($urandom_range(0, 15)),
                  $urandom, $urandom, int'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", rq.size() + bq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_bus.md
# lsu_bus

Load/store unit that sits between the RV32I core's data-memory port and a wait-stated memory bus. It turns one core load/store into a single valid/ready bus transaction, generates byte enables and lane-replicated write data, and sign- or zero-extends load data. It stalls the core while the access is outstanding and reports misaligned, illegal-width and timed-out accesses as faults instead of issuing them.

## Interface
Parameters:
- TIMEOUT, 255: bus cycles waited for bus_ready before aborting; range 1-255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  1  core requests a memory op; held until the done cycle.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  access width: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- stall  out  1  core must not advance PC or write the register file.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load data; valid only when done=1 and we=0.
- fault  out  1  qualifies done: access not performed.
- fault_cause  out  2  01 misaligned, 10 timeout, 11 illegal funct3; 00 when fault=0.
- bus_valid  out  1  request valid.
- bus_ready  in  1  memory accepts the request and returns read data this cycle.
- bus_we  out  1  write strobe.
- bus_addr  out  32  word address, addr[1:0] forced to 00.
- bus_be  out  4  byte lanes.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read word; sampled when bus_valid and bus_ready are both 1.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: stall = req, combinational. On req:
  - legal and aligned: register we, bus_addr, bus_be, bus_wdata, funct3 and addr[1:0]; go to BUS.
  - otherwise: latch fault and cause; go to RESP with no bus activity.
- Illegal: funct3 in {011, 110, 111}, or a store with funct3[2]=1. Illegal takes priority over misaligned.
- Misaligned: h/hu with addr[0]=1, or w with addr[1:0] != 00.
- BUS: bus_valid=1 and stall=1; all bus outputs are held stable.
  - bus_ready=1: capture bus_rdata and go to RESP.
  - Otherwise the wait counter increments. When it reaches TIMEOUT, latch fault=1, cause=10, drop bus_valid, and go to RESP.
- RESP: done=1, stall=0, rdata/fault driven from registers; go to IDLE unconditionally. A req seen in RESP belongs to the completing instruction and is not relaunched.
- Byte enables, where off = addr[1:0]:
  - b: 0001<<off.
  - h: 0011<<off (off is 0 or 2).
  - w: 1111.
- Write data:
  - sb: {4{wdata[7:0]}}.
  - sh: {2{wdata[15:0]}}.
  - sw: wdata.
- Load data, using the saved off:
  - lb/lbu: byte off, sign/zero extended.
  - lh/lhu: halfword off[1], sign/zero extended.
  - lw: full word.
- rdata = 0 on stores and faults.

## Timing
- Reset values: state=IDLE; stall follows req combinationally. All other outputs are 0: done, fault, fault_cause, rdata, bus_valid, bus_we, bus_addr, bus_be, bus_wdata. The wait counter is 0.
- Reset asserted mid-transaction: bus_valid drops asynchronously and the transaction is abandoned; the memory must tolerate this.
- Latency, with req first seen in IDLE at cycle 0:
  - BUS occupies cycle 1 through the bus_ready cycle.
  - bus_ready in cycle k gives RESP (done) in cycle k+1.
  - Zero-wait access: done in cycle 2; stall is high in cycles 0-1.
- Fault without bus activity: done+fault in cycle 1.
- Timeout: bus_valid is high for exactly TIMEOUT cycles; done+fault follows in the next cycle.
- Back-to-back: a new req in the cycle after RESP (IDLE) launches immediately. Throughput is one access per 3 cycles at best.
- Wait counter: 8-bit, cleared on entry to BUS, never wraps.

## Test plan
- sw addr=0x64 wdata=0x19, bus_ready at first BUS cycle -> bus_addr=0x64, be=1111, bus_wdata=0x00000019, done cycle 2, stall high cycles 0-1.
- sb addr=0x103 wdata=0xAB -> bus_addr=0x100, be=1000, bus_wdata=0xABABABAB.
- lh addr=0x22, bus_rdata=0x8001_7FFF -> rdata=0xFFFF8001. lhu at the same address -> 0x00008001. lb addr=0x21 -> 0x0000007F.
- lw addr=0x66 -> no bus_valid ever, done+fault in cycle 1, cause=01. sb with funct3=100 -> cause=11.
- TIMEOUT=4, bus_ready held 0 -> bus_valid high for 4 cycles, then done, fault=1, cause=10.
- Reset pulsed during BUS with bus_ready=0 -> bus_valid=0 immediately; after release a new lw completes normally.
